// File: rtl/stream_mux_if.sv
// Handshake and output-lane bundle shared by the stream sources, the scheduler and the framer.
interface stream_mux_if #(
  parameter int DW = 16
);
  logic [4*DW-1:0] ds_data;
  logic [3:0]      ds_valid;
  logic [3:0]      ds_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic [1:0]      out_sel;
  logic            slot_start;

  modport master (
    output ds_data, ds_valid,
    input  ds_ready, out_data, out_valid, out_sel, slot_start
  );

  modport slave (
    input  ds_data, ds_valid,
    output ds_ready, out_data, out_valid, out_sel, slot_start
  );
endinterface

// File: rtl/stream_mux_scheduler.sv
// Slot scheduler time-sharing one output lane between four valid/ready streams.
// Define STREAM_MUX_RR_MODE_EN to build the work-conserving round-robin mode (mode 2).
module stream_mux_scheduler #(
  parameter int DW    = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] slot_cycles,
  input  logic [3:0]       stream_en,
  stream_mux_if.slave      bus
);

  // state  | meaning
  // IDLE   | scheduler off (mode 0 or no stream enabled), no ready
  // WAIT   | round-robin with nothing valid, re-searching every cycle
  // SLOT   | stream ptr owns the lane, ready asserted to it
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SLOT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rr_q, rr_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic             slot_start_q, slot_start_d;

  logic             rr_sel;
  logic [3:0]       elig;
  logic [2:0]       grant;
  logic             cfg_on;
  logic [CNT_W-1:0] slot_len_m1;
  logic             xfer;
  logic             slot_end;

`ifdef STREAM_MUX_RR_MODE_EN
  assign rr_sel = (mode == 2'd2);
`else
  assign rr_sel = 1'b0;
`endif

  // {found, index}: first eligible stream after p, wrapping back to p itself last
  function automatic logic [2:0] next_grant(input logic [1:0] p, input logic [3:0] e);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (e[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign elig        = rr_sel ? (stream_en & bus.ds_valid) : stream_en;
  assign grant       = next_grant(ptr_q, elig);
  assign cfg_on      = (mode != 2'd0) && (stream_en != 4'd0);
  assign slot_len_m1 = (slot_cycles == '0) ? '0 : slot_cycles - CNT_W'(1);
  assign xfer        = (state_q == S_SLOT) && bus.ds_valid[ptr_q];
  assign slot_end    = (state_q == S_SLOT) &&
                       ((cnt_q == '0) || (rr_q && !bus.ds_valid[ptr_q]));

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;
    slot_start_d = 1'b0;
    out_valid_d  = xfer;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;

    if (xfer) begin
      out_data_d = bus.ds_data[ptr_q*DW +: DW];
      out_sel_d  = ptr_q;
    end

    // Configuration is only looked at here, at a slot boundary or while not in a slot
    if ((state_q != S_SLOT) || slot_end) begin
      if (!cfg_on) begin
        state_d = S_IDLE;
      end else if (grant[2]) begin
        state_d      = S_SLOT;
        ptr_d        = grant[1:0];
        cnt_d        = slot_len_m1;
        rr_d         = rr_sel;
        slot_start_d = 1'b1;
      end else begin
        state_d = S_WAIT;
      end
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= 2'd3;
      cnt_q        <= '0;
      rr_q         <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_sel_q    <= 2'd0;
      slot_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_sel_q    <= out_sel_d;
      slot_start_q <= slot_start_d;
    end
  end

  // Ready depends on state and pointer only, so sources may wait for it before raising valid
  assign bus.ds_ready   = (state_q == S_SLOT) ? (4'b0001 << ptr_q) : 4'b0000;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sel    = out_sel_q;
  assign bus.slot_start = slot_start_q;

endmodule

// File: tb/tb_stream_mux_scheduler.sv
// Directed bench for stream_mux_scheduler: slot-level reference model compared every cycle plus literal checks.
module tb_stream_mux_scheduler;
  localparam int DW    = 16;
  localparam int CNT_W = 32;

`ifdef STREAM_MUX_RR_MODE_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       mode;
  logic [CNT_W-1:0] slot_cycles;
  logic [3:0]       stream_en;

  stream_mux_if #(.DW(DW)) bus();

  stream_mux_scheduler #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .slot_cycles(slot_cycles),
    .stream_en  (stream_en),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model: a slot is "stream s owns the lane for left more cycles"
  bit          m_active = 1'b0;
  int          m_str    = 0;
  int          m_last   = 3;
  longint      m_left   = 0;
  bit          m_rr     = 1'b0;
  logic [3:0]  e_ready  = 4'b0;
  logic        e_valid  = 1'b0;
  logic [15:0] e_data   = 16'h0;
  logic [1:0]  e_sel    = 2'd0;
  logic        e_start  = 1'b0;

  function automatic int pick(int last, logic [3:0] en, logic [3:0] v, bit rr);
    int s;
    for (int k = 1; k <= 4; k++) begin
      s = (last + k) % 4;
      if (en[s] && (!rr || v[s])) return s;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit xfer_m;
    bit boundary;
    bit rr_now;
    int s;
    if (rst) begin
      m_active = 1'b0; m_last = 3; m_left = 0; m_rr = 1'b0; m_str = 0;
      e_ready = 4'b0; e_valid = 1'b0; e_data = 16'h0; e_sel = 2'd0; e_start = 1'b0;
    end else begin
      xfer_m  = m_active && bus.ds_valid[m_str];
      e_valid = xfer_m;
      if (xfer_m) begin
        e_data = bus.ds_data[m_str*DW +: DW];
        e_sel  = 2'(m_str);
      end
      boundary = !m_active || (m_left == 1) || (m_rr && !bus.ds_valid[m_str]);
      e_start  = 1'b0;
      if (boundary) begin
        rr_now = RR_BUILD && (mode == 2'd2);
        if (mode == 2'd0 || stream_en == 4'd0) begin
          m_active = 1'b0;
        end else begin
          s = pick(m_last, stream_en, bus.ds_valid, rr_now);
          if (s >= 0) begin
            m_active = 1'b1; m_str = s; m_last = s; m_rr = rr_now; e_start = 1'b1;
            m_left   = (slot_cycles == 0) ? 1 : longint'(slot_cycles);
          end else begin
            m_active = 1'b0;
          end
        end
      end else begin
        m_left = m_left - 1;
      end
      e_ready = m_active ? 4'(1 << m_str) : 4'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    n_chk++;
    if ({bus.ds_ready, bus.out_valid, bus.out_data, bus.out_sel, bus.slot_start} ===
        {e_ready, e_valid, e_data, e_sel, e_start})
      n_pass++;
    else
      $display("FAIL model t=%0t got ready=%b valid=%b data=%h sel=%0d start=%b, want ready=%b valid=%b data=%h sel=%0d start=%b",
               $time, bus.ds_ready, bus.out_valid, bus.out_data, bus.out_sel, bus.slot_start,
               e_ready, e_valid, e_data, e_sel, e_start);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int oh_idx(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n_start, n_valid, n_r1, run, maxrun, g;
    logic [3:0] rd [0:4];
    logic [1:0] sl [0:4];
    bit found;

    mode         = 2'd0;
    slot_cycles  = '0;
    stream_en    = 4'b0;
    bus.ds_valid = 4'b0;
    bus.ds_data  = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset ds_ready",   32'(bus.ds_ready),   32'h0);
    chk("reset out_valid",  32'(bus.out_valid),  32'h0);
    chk("reset out_data",   32'(bus.out_data),   32'h0);
    chk("reset out_sel",    32'(bus.out_sel),    32'h0);
    chk("reset slot_start", 32'(bus.slot_start), 32'h0);

    // TDM, two streams, 4-cycle slots, released from reset with config already valid
    mode = 2'd1; slot_cycles = 4; stream_en = 4'b0011; bus.ds_valid = 4'b1111; rst = 1'b0;
    n_start = 0; n_valid = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (bus.slot_start) n_start++;
      if (bus.out_valid)  n_valid++;
      if (k == 1) begin
        chk("startup ds_ready",   32'(bus.ds_ready),   32'h1);
        chk("startup slot_start", 32'(bus.slot_start), 32'h1);
      end
      if (k == 2)  chk("tdm first beat", 32'(bus.out_data), 32'hAAAA);
      if (k == 5) begin
        chk("tdm last A beat",    32'(bus.out_data), 32'hAAAA);
        chk("tdm slot1 ds_ready", 32'(bus.ds_ready), 32'h2);
      end
      if (k == 6) begin
        chk("tdm first B beat", 32'(bus.out_data), 32'hBBBB);
        chk("tdm B out_sel",    32'(bus.out_sel),  32'h1);
      end
      if (k == 10) chk("tdm A again", 32'(bus.out_data), 32'hAAAA);
    end
    chk("tdm slot_start count", 32'(n_start), 32'd4);
    chk("tdm out_valid count",  32'(n_valid), 32'd15);

    // One-cycle slots over all four streams
    slot_cycles = 0; stream_en = 4'b1111;
    repeat (10) @(negedge clk);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      rd[k] = bus.ds_ready;
      sl[k] = bus.out_sel;
    end
    for (int k = 0; k < 4; k++) begin
      chk("1cyc ready one-hot",  32'($countones(rd[k])), 32'd1);
      chk("1cyc ready rotates",  32'(rd[k+1]), 32'({rd[k][2:0], rd[k][3]}));
      chk("1cyc out_sel follows", 32'(sl[k+1]), 32'(oh_idx(rd[k])));
    end

    // TDM with stream 1 idle: its slot keeps full length with no output
    slot_cycles = 4; stream_en = 4'b0011; bus.ds_valid = 4'b0001;
    repeat (12) @(negedge clk);
    n_valid = 0; n_r1 = 0; run = 0; maxrun = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin n_valid++; run = 0; end
      else begin run++; if (run > maxrun) maxrun = run; end
      if (bus.ds_ready == 4'b0010) n_r1++;
    end
    chk("idle stream valid count",  32'(n_valid), 32'd8);
    chk("idle stream ready cycles", 32'(n_r1),    32'd8);
    chk("idle stream gap length",   32'(maxrun),  32'd4);

    // Mode 2: round-robin when built in, otherwise plain TDM
    mode = 2'd0;
    repeat (6) @(negedge clk);
    chk("mode0 ds_ready", 32'(bus.ds_ready), 32'h0);
    bus.ds_valid = 4'b0; slot_cycles = 8; stream_en = 4'b1111; mode = 2'd2;
`ifdef STREAM_MUX_RR_MODE_EN
    repeat (2) @(negedge clk);
    chk("rr wait ds_ready", 32'(bus.ds_ready), 32'h0);
    bus.ds_valid = 4'b0100; n_valid = 0;
    @(negedge clk);
    chk("rr grant ds_ready",   32'(bus.ds_ready),   32'h4);
    chk("rr grant slot_start", 32'(bus.slot_start), 32'h1);
    @(negedge clk);
    if (bus.out_valid) n_valid++;
    chk("rr beat data", 32'(bus.out_data), 32'hCCCC);
    @(negedge clk);
    if (bus.out_valid) n_valid++;
    bus.ds_valid = 4'b0;
    @(negedge clk);
    if (bus.out_valid) n_valid++;
    chk("rr early end ds_ready", 32'(bus.ds_ready), 32'h0);
    @(negedge clk);
    if (bus.out_valid) n_valid++;
    chk("rr beat count", 32'(n_valid), 32'd2);
    bus.ds_valid = 4'b0100;
    @(negedge clk);
    chk("rr regrant ds_ready",   32'(bus.ds_ready),   32'h4);
    chk("rr regrant slot_start", 32'(bus.slot_start), 32'h1);
`else
    bus.ds_valid = 4'b1111;
    g = 0;
    do begin @(negedge clk); g++; end while (!bus.slot_start && g < 20);
    chk("mode2 first slot seen", 32'(bus.slot_start), 32'h1);
    rd[0] = bus.ds_ready;
    for (int k = 1; k <= 3; k++) begin
      g = 0;
      do begin @(negedge clk); g++; end while (!bus.slot_start && g < 20);
      chk("mode2 slot length",   32'(g), 32'd8);
      rd[k] = bus.ds_ready;
      chk("mode2 ready rotates", 32'(rd[k]), 32'({rd[k-1][2:0], rd[k-1][3]}));
    end
`endif

    // Mid-slot slot_cycles change only applies from the next slot
    mode = 2'd1; slot_cycles = 4; stream_en = 4'b1111; bus.ds_valid = 4'b1111;
    g = 0;
    do begin @(negedge clk); g++; end while (!bus.slot_start && g < 30);
    chk("midcfg sync", 32'(bus.slot_start), 32'h1);
    g = 0;
    do begin
      @(negedge clk); g++;
      if (g == 1) slot_cycles = 8;
    end while (!bus.slot_start && g < 40);
    chk("midcfg current slot length", 32'(g), 32'd4);
    g = 0;
    do begin @(negedge clk); g++; end while (!bus.slot_start && g < 40);
    chk("midcfg next slot length", 32'(g), 32'd8);

    // Reset pulse in cycle 2 of stream 1's slot
    slot_cycles = 4; stream_en = 4'b0011;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (bus.slot_start && bus.ds_ready == 4'b0010) found = 1'b1;
    end
    chk("reset test stream1 slot found", 32'(found), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst ds_ready",   32'(bus.ds_ready),   32'h0);
    chk("midrst out_valid",  32'(bus.out_valid),  32'h0);
    chk("midrst out_data",   32'(bus.out_data),   32'h0);
    chk("midrst out_sel",    32'(bus.out_sel),    32'h0);
    chk("midrst slot_start", 32'(bus.slot_start), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset grant stream0", 32'(bus.ds_ready),   32'h1);
    chk("post-reset slot_start",    32'(bus.slot_start), 32'h1);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
